// File: rtl/mult_accumulator_pkg.sv
// Shared types and width helpers for the multiply-accumulate stage.
package mult_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int acc_width(input int size, input int guard);
    return 2 * size + guard;
  endfunction

endpackage

// File: rtl/mult_acc_ctrl.sv
// Sequencing for the accumulator: run FSM, product down-counter, handshake flags.
module mult_acc_ctrl
  import mult_accumulator_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] length_i,
  input  logic               prod_valid_i,
  input  logic               acc_ready_i,
  output logic               prod_ready_o,
  output logic               acc_valid_o,
  output logic               busy_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               accept_o,
  output logic               clear_o
);

  state_e             state_q;
  logic [COUNT_W-1:0] count_q;
  logic               ready_q;
  logic               valid_q;
  logic               busy_q;

  // NOTE: accept and clear are combinational strobes, but they only feed
  // internal registers; every port-level output below comes from a flop.
  assign accept_o = prod_valid_i & ready_q;
  assign clear_o  = start_i & (state_q == IDLE);

  assign prod_ready_o = ready_q;
  assign acc_valid_o  = valid_q;
  assign busy_o       = busy_q;
  assign count_o      = count_q;

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (length_i != '0) begin
              count_q <= length_i;
              ready_q <= 1'b1;
              state_q <= ACCUM;
            end else begin
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (accept_o) begin
            count_q <= count_q - COUNT_W'(1);
            if (count_q == COUNT_W'(1)) begin
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (acc_ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mult_accumulator.sv
// Accumulates a programmed number of unsigned products into a wide sum with
// a sticky wrap flag; sequencing lives in mult_acc_ctrl.
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter  int SIZE      = 16,
  parameter  int ACC_GUARD = 8,
  parameter  int COUNT_W   = 8,
  localparam int ACC_W     = acc_width(SIZE, ACC_GUARD)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [COUNT_W-1:0] iLength,
  input  logic               iProdValid,
  input  logic [2*SIZE-1:0]  iProduct,
  output logic               oProdReady,
  output logic               oAccValid,
  output logic [ACC_W-1:0]   oAcc,
  input  logic               iAccReady,
  output logic               oOverflow,
  output logic               oBusy,
  output logic [COUNT_W-1:0] oCount
);

  logic             accept;
  logic             clear;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W:0]   sum_w;

  mult_acc_ctrl #(.COUNT_W(COUNT_W)) u_ctrl (
    .Clock        (Clock),
    .Reset        (Reset),
    .start_i      (iStart),
    .length_i     (iLength),
    .prod_valid_i (iProdValid),
    .acc_ready_i  (iAccReady),
    .prod_ready_o (oProdReady),
    .acc_valid_o  (oAccValid),
    .busy_o       (oBusy),
    .count_o      (oCount),
    .accept_o     (accept),
    .clear_o      (clear)
  );

  // One extra bit captures the carry out of the accumulator MSB.
  assign sum_w = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(iProduct);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= sum_w[ACC_W-1:0];
      if (sum_w[ACC_W]) ovf_q <= 1'b1;
    end
  end

  assign oAcc      = acc_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: a default-size instance and a narrow
// SIZE=4/ACC_GUARD=0 instance for wrap behaviour; final sums via a scoreboard.
module tb_mult_accumulator;

  typedef struct {
    logic [39:0] acc;
    logic        ovf;
  } exp_t;

  logic Clock;
  logic Reset;

  logic        st_a, pv_a, ar_a, ready_a, valid_a, ovf_a, busy_a;
  logic [7:0]  len_a, cnt_a;
  logic [31:0] prod_a;
  logic [39:0] acc_a;

  logic        st_b, pv_b, ar_b, ready_b, valid_b, ovf_b, busy_b;
  logic [7:0]  len_b, cnt_b, prod_b, acc_b;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  mult_accumulator dut_a (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (st_a),
    .iLength    (len_a),
    .iProdValid (pv_a),
    .iProduct   (prod_a),
    .oProdReady (ready_a),
    .oAccValid  (valid_a),
    .oAcc       (acc_a),
    .iAccReady  (ar_a),
    .oOverflow  (ovf_a),
    .oBusy      (busy_a),
    .oCount     (cnt_a)
  );

  mult_accumulator #(.SIZE(4), .ACC_GUARD(0)) dut_b (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (st_b),
    .iLength    (len_b),
    .iProdValid (pv_b),
    .iProduct   (prod_b),
    .oProdReady (ready_b),
    .oAccValid  (valid_b),
    .oAcc       (acc_b),
    .iAccReady  (ar_b),
    .oOverflow  (ovf_b),
    .oBusy      (busy_b),
    .oCount     (cnt_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [39:0] acc, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic score(input string tag, input logic [39:0] acc, input logic ovf);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=result expected=no pending entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_acc"}, 64'(acc), 64'(e.acc));
      check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
    end
  endtask

  initial begin
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int idx;

    Reset = 1'b1;
    st_a = 0; len_a = 0; pv_a = 0; prod_a = 0; ar_a = 0;
    st_b = 0; len_b = 0; pv_b = 0; prod_b = 0; ar_b = 0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_acc",   64'(acc_a),   64'd0);
    check("rst_cnt",   64'(cnt_a),   64'd0);
    check("rst_ovf",   64'(ovf_a),   64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_ready", 64'(ready_a), 64'd0);
    check("rst_busy",  64'(busy_a),  64'd0);

    // Three back-to-back products, downstream always ready.
    st_a = 1; len_a = 3; ar_a = 1;
    push(40'd126, 1'b0);
    tick();
    st_a = 0;
    check("t1_cnt",   64'(cnt_a),   64'd3);
    check("t1_ready", 64'(ready_a), 64'd1);
    check("t1_busy",  64'(busy_a),  64'd1);
    pv_a = 1; prod_a = 6;   tick();
    check("t1_valid_early", 64'(valid_a), 64'd0);
    prod_a = 20;  tick();
    prod_a = 100; tick();
    pv_a = 0;
    check("t1_valid", 64'(valid_a), 64'd1);
    score("t1", acc_a, ovf_a);
    tick();
    check("t1_idle_valid", 64'(valid_a), 64'd0);
    check("t1_idle_busy",  64'(busy_a),  64'd0);

    // Bursty valid: only cycles with valid high consume a product.
    st_a = 1; len_a = 4; ar_a = 0;
    push(40'd10, 1'b0);
    tick();
    st_a = 0;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      pv_a = pat[i];
      prod_a = 32'(idx + 1);
      tick();
      if (pat[i]) idx++;
      if (i == 2) check("t2_cnt_mid", 64'(cnt_a), 64'd3);
    end
    pv_a = 0;
    check("t2_valid", 64'(valid_a), 64'd1);
    check("t2_ready", 64'(ready_a), 64'd0);
    check("t2_cnt",   64'(cnt_a),   64'd0);
    score("t2", acc_a, ovf_a);
    ar_a = 1; tick(); ar_a = 0;
    check("t2_idle", 64'(busy_a), 64'd0);

    // Zero-length run goes straight to HOLD and stays while stalled.
    st_a = 1; len_a = 0;
    push(40'd0, 1'b0);
    tick();
    st_a = 0;
    check("t4_valid", 64'(valid_a), 64'd1);
    score("t4", acc_a, ovf_a);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_acc",   64'(acc_a),   64'd0);
      check("t4_hold_valid", 64'(valid_a), 64'd1);
    end
    ar_a = 1; tick(); ar_a = 0;
    check("t4_idle", 64'(valid_a), 64'd0);

    // Starts outside IDLE are ignored.
    st_a = 1; len_a = 2;
    push(40'd57, 1'b0);
    tick();
    len_a = 9;
    pv_a = 1; prod_a = 50; tick();
    check("t5_cnt_a", 64'(cnt_a), 64'd1);
    pv_a = 0; tick();
    check("t5_cnt_b", 64'(cnt_a), 64'd1);
    st_a = 0; pv_a = 1; prod_a = 7; tick();
    pv_a = 0;
    check("t5_valid", 64'(valid_a), 64'd1);
    score("t5", acc_a, ovf_a);
    st_a = 1; ar_a = 1; tick();
    st_a = 0; ar_a = 0;
    check("t5_idle_busy",  64'(busy_a),  64'd0);
    check("t5_idle_valid", 64'(valid_a), 64'd0);
    tick();
    check("t5_still_idle", 64'(busy_a), 64'd0);
    check("t5_keep_acc",   64'(acc_a),  64'd57);

    // Reset mid-accumulation discards the partial sum.
    st_a = 1; len_a = 5; tick(); st_a = 0;
    pv_a = 1; prod_a = 1; tick(); tick();
    check("t6_partial", 64'(acc_a), 64'd2);
    pv_a = 0; Reset = 1; tick(); Reset = 0;
    check("t6_rst_acc",   64'(acc_a),   64'd0);
    check("t6_rst_cnt",   64'(cnt_a),   64'd0);
    check("t6_rst_busy",  64'(busy_a),  64'd0);
    check("t6_rst_ready", 64'(ready_a), 64'd0);
    check("t6_rst_valid", 64'(valid_a), 64'd0);
    check("t6_rst_ovf",   64'(ovf_a),   64'd0);
    st_a = 1; len_a = 1; push(40'd7, 1'b0); tick(); st_a = 0;
    pv_a = 1; prod_a = 7; tick(); pv_a = 0;
    check("t6_valid", 64'(valid_a), 64'd1);
    score("t6", acc_a, ovf_a);
    ar_a = 1; tick(); ar_a = 0;

    // Narrow instance: 225+225 wraps an 8-bit accumulator.
    st_b = 1; len_b = 2; push(40'd194, 1'b1); tick(); st_b = 0;
    pv_b = 1; prod_b = 225; tick(); tick(); pv_b = 0;
    check("t3_valid", 64'(valid_b), 64'd1);
    score("t3", 40'(acc_b), ovf_b);
    ar_b = 1; tick(); ar_b = 0;
    check("t3_ovf_sticky", 64'(ovf_b), 64'd1);
    st_b = 1; len_b = 1; push(40'd5, 1'b0); tick(); st_b = 0;
    check("t3_ovf_clear", 64'(ovf_b), 64'd0);
    pv_b = 1; prod_b = 5; tick(); pv_b = 0;
    check("t3b_valid", 64'(valid_b), 64'd1);
    score("t3b", 40'(acc_b), ovf_b);
    ar_b = 1; tick(); ar_b = 0;

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
Downstream consumer of the combinational array multiplier output; it accumulates a programmed number of unsigned 2*SIZE-bit products into a wide running sum. Products arrive through a valid/ready handshake, one per cycle at most. The finished sum is presented through a second valid/ready handshake, with a sticky overflow flag. It is the first sequential stage after the multiplier in the datapath.

Parameters:
SIZE, 16, multiplier operand width; product width is 2*SIZE
ACC_GUARD, 8, extra accumulator bits above the product width; accumulator width ACC_W = 2*SIZE+ACC_GUARD
COUNT_W, 8, width of the product-count field

Ports:
Clock  input  1  system clock; all state changes on its rising edge
Reset  input  1  synchronous, active-high reset
iStart  input  1  start a new accumulation; sampled only in IDLE
iLength  input  COUNT_W  number of products to accumulate; sampled together with iStart
iProdValid  input  1  iProduct holds a valid product
iProduct  input  2*SIZE  unsigned product from the multiplier
oProdReady  output  1  block accepts a product this cycle
oAccValid  output  1  oAcc holds the final sum
oAcc  output  ACC_W  accumulated sum
iAccReady  input  1  downstream takes oAcc
oOverflow  output  1  sticky: the sum wrapped during this accumulation
oBusy  output  1  high in ACCUM and HOLD
oCount  output  COUNT_W  products still to accept

Behaviour:
- Reset (any state, including mid-accumulation): state=IDLE; oAcc=0, oCount=0, oOverflow=0, oAccValid=0, oProdReady=0, oBusy=0. Any partial sum is discarded.
- FSM states: IDLE, ACCUM, HOLD. All outputs are registered or decoded from state only; there is no combinational path from an input to an output.
- IDLE: oProdReady=0.
  - iStart=1 and iLength!=0: oAcc<=0, oOverflow<=0, oCount<=iLength, go to ACCUM.
  - iStart=1 and iLength==0: oAcc<=0, oOverflow<=0, go directly to HOLD (zero-length result is 0).
  - iStart=0: stay in IDLE. oAcc and oOverflow keep their last values.
- ACCUM: oProdReady=1. A product is accepted when iProdValid and oProdReady are both 1 in the same cycle.
  - On accept: oAcc <= oAcc + zero-extended iProduct, modulo 2^ACC_W. A carry out of bit ACC_W-1 sets oOverflow (sticky until the next start). oCount <= oCount-1.
  - Accept with oCount==1: go to HOLD.
  - iProdValid=0: no change. There is no timeout.
- HOLD: oAccValid=1, oProdReady=0; oAcc and oOverflow are stable.
  - iAccReady=1: go to IDLE; oAccValid falls the next cycle.
  - iStart is ignored in HOLD, including in the same cycle as iAccReady. A new start needs an IDLE cycle.
- Latency: oAccValid rises the cycle after the last product is accepted. Throughput is one product per cycle. The minimum total is N+2 cycles from iStart to back in IDLE for N>0, with iAccReady held high.
- iStart outside IDLE: ignored, no effect on count or sum.
- All arithmetic is unsigned, with no saturation.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and the ACC_W derivation.
- One sub-module, mult_acc_ctrl, holds the FSM plus the down-counter (oCount, oProdReady, oAccValid, oBusy, accept strobe).
- The top level holds the accumulator register, the adder with carry-out, and the sticky overflow register.

Test Plan:
- Defaults; iStart with iLength=3; products 6, 20, 100 on consecutive cycles; iAccReady=1 -> oAccValid the cycle after the third accept, oAcc=126, oOverflow=0, IDLE one cycle later.
- iLength=4; iProdValid toggled 1,0,0,1,1,0,1 with products 1,2,3,4 -> exactly 4 accepts, oAcc=10, oProdReady low in HOLD.
- SIZE=4, ACC_GUARD=0 (ACC_W=8); iLength=2, products 225, 225 -> oAcc=194, oOverflow=1; next run with iLength=1, product 5 -> oAcc=5, oOverflow=0.
- iLength=0 with iStart -> HOLD on the next cycle, oAcc=0, oAccValid=1; hold iAccReady=0 for 5 cycles -> oAcc and oAccValid stable.
- iStart pulsed in ACCUM and again with iAccReady in HOLD -> both ignored: count unaffected, return to IDLE, no new run.
- iLength=5, Reset asserted after 2 accepts -> next cycle all outputs 0, state IDLE; a fresh run with iLength=1, product 7 gives oAcc=7.
